nor_tree_pipe: RTL

- Parametrised, pipelined successor to the two-input CMOS NOR cell.
- Reduces each of CHANNELS independent WIDTH-bit input vectors to one NOR (or OR) bit through a registered tree of two-input gates.
- The tree alternates NOR and NAND levels, one register per level.
- Sits between bus-level producers and consumers; uses valid/ready flow control with full back-pressure.

---
 rtl/nor_tree_pkg.sv | 24 ++
 rtl/nor_tree_pipe_gate2.sv | 28 ++
 rtl/nor_tree_pipe_stage.sv | 84 ++++++++
 rtl/nor_tree_pipe.sv | 70 +++++++
 4 files changed

// File: rtl/nor_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined NOR/OR reduction tree.
package nor_tree_pkg;

    localparam logic MODE_NOR = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Level 1 is a NOR level, then the tree alternates with NAND.
    function automatic logic level_is_nor(input int k);
        return k[0];
    endfunction

endpackage

// File: rtl/nor_tree_pipe_gate2.sv
// Two-input static CMOS leaf cell: NOR (series pull-up, parallel pull-down) or its NAND dual.
module gate2 #(
    parameter bit IS_NOR = 1'b1
) (
    input  wire a,
    input  wire b,
    output wire y
);

    supply1 vdd;
    supply0 gnd;
    wire    mid;

    generate
        if (IS_NOR) begin : g_nor
            pmos p_a (mid, vdd, a);
            pmos p_b (y,   mid, b);
            nmos n_a (y,   gnd, a);
            nmos n_b (y,   gnd, b);
        end else begin : g_nand
            pmos p_a (y,   vdd, a);
            pmos p_b (y,   vdd, b);
            nmos n_b (mid, gnd, b);
            nmos n_a (y,   mid, a);
        end
    endgenerate

endmodule

// File: rtl/nor_tree_pipe_stage.sv
// One registered tree level: IN_W/2 two-input gates plus valid/mode/data registers.
module nor_tree_stage
    import nor_tree_pkg::*;
#(
    parameter int LEVEL     = 1,
    parameter int IN_W      = 16,
    parameter bit IS_LAST   = 1'b0,
    parameter bit RAW_IS_OR = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_valid,
    input  logic                up_mode,
    input  logic [IN_W-1:0]     up_data,
    input  logic                dn_adv,
    output logic                stage_valid,
    output logic                stage_mode,
    output logic [IN_W/2-1:0]   stage_data
);

    localparam int OUT_W  = IN_W / 2;
    localparam bit IS_NOR = level_is_nor(LEVEL);

    wire  [OUT_W-1:0] gate_y;
    logic [OUT_W-1:0] data_in;
    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;
    logic             valid_d;
    logic             valid_q;
    logic             mode_d;
    logic             mode_q;
    logic             advance;

    genvar j;
    generate
        for (j = 0; j < OUT_W; j++) begin : g_gate
            gate2 #(.IS_NOR(IS_NOR)) u_gate (
                .a (up_data[2*j]),
                .b (up_data[2*j+1]),
                .y (gate_y[j])
            );
        end
    endgenerate

    // The final level folds in the beat's mode so the output register holds the finished result.
    always_comb begin
        data_in = gate_y;
        if (IS_LAST) begin
            data_in = gate_y ^ {OUT_W{(up_mode == MODE_OR) ^ RAW_IS_OR}};
        end
    end

    assign advance = !valid_q || dn_adv;

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = up_valid;
            if (up_valid) begin
                mode_d = up_mode;
                data_d = data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign stage_valid = valid_q;
    assign stage_mode  = mode_q;
    assign stage_data  = data_q;

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined per-channel NOR/OR reduction with valid/ready flow control and full back-pressure.
module nor_tree_pipe
    import nor_tree_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_data
);

    localparam int LEVELS    = clog2(WIDTH);
    localparam int TOTAL_W   = CHANNELS * WIDTH;
    localparam int BUS_W     = 2 * TOTAL_W - CHANNELS;
    localparam bit RAW_IS_OR = (LEVELS % 2) == 0;

    // tree_bus packs every level back to back: in_data first, then each stage's registered output.
    logic [BUS_W-1:0]    tree_bus;
    logic [LEVELS:0]     valid_vec;
    logic [LEVELS:0]     mode_vec;
    logic [LEVELS+1:1]   adv_vec;
    logic                last_mode_unused;

    assign tree_bus[TOTAL_W-1:0] = in_data;
    assign valid_vec[0]          = in_valid;
    assign mode_vec[0]           = in_mode;
    assign adv_vec[LEVELS+1]     = out_ready;

    genvar k;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int IN_W    = TOTAL_W >> (k - 1);
            localparam int IN_OFF  = 2 * TOTAL_W - 2 * IN_W;
            localparam int OUT_OFF = IN_OFF + IN_W;

            // Stage k moves when the consumer takes a result or any stage from k onward has a hole.
            assign adv_vec[k] = out_ready || !(&valid_vec[LEVELS:k]);

            nor_tree_stage #(
                .LEVEL     (k),
                .IN_W      (IN_W),
                .IS_LAST   (k == LEVELS),
                .RAW_IS_OR (RAW_IS_OR)
            ) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .up_valid    (valid_vec[k-1]),
                .up_mode     (mode_vec[k-1]),
                .up_data     (tree_bus[IN_OFF +: IN_W]),
                .dn_adv      (adv_vec[k+1]),
                .stage_valid (valid_vec[k]),
                .stage_mode  (mode_vec[k]),
                .stage_data  (tree_bus[OUT_OFF +: IN_W/2])
            );
        end
    endgenerate

    assign in_ready         = adv_vec[1];
    assign out_valid        = valid_vec[LEVELS];
    assign out_data         = tree_bus[BUS_W-1 -: CHANNELS];
    assign last_mode_unused = mode_vec[LEVELS];

endmodule
